exe_mem_reg: RTL
================

# exe_mem_reg

EXE→MEM pipeline register of the five-stage core. Captures the EXE-stage result bundle every enabled cycle and presents it as the MEM-stage bundle. That bundle drives the EXE-stage forward unit (`MEM_Dst`, `MEM_RegsWrType`, `MEM_ALUOut`), the data-memory request logic and the hazard unit. It owns stall/flush bubble semantics for this boundary and suppresses architectural writes from invalid or faulting instructions.

## Interface
Parameters:
- `PC_RESET` — 32'hBFC0_0000 — PC value loaded on reset or flush.

Ports:
- `clk` in 1 — core clock; all state updates on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `MEM_Flush` in 1 — inserts a bubble at this boundary.
- `MEM_Wr` in 1 — capture enable; 0 holds current contents (stall).
- `EXE_Valid` in 1 — EXE slot holds a real instruction.
- `EXE_PC` in 32 — instruction PC.
- `EXE_ALUOut` in 32 — ALU result or effective address.
- `EXE_OutB` in 32 — forwarded rt value (store data).
- `EXE_Dst` in 5 — destination GPR.
- `EXE_RegsWrType` in 4 — {RFWr, CP0Wr, HIWr, LOWr}.
- `EXE_LoadType` in 3 — 0 = none, 1..5 = LB/LBU/LH/LHU/LW.
- `EXE_StoreType` in 2 — 0 = none, 1..3 = SB/SH/SW.
- `EXE_IsInDelaySlot` in 1 — branch delay slot flag.
- `EXE_HasExc` in 1 — exception raised at or before EXE.
- `EXE_ExcCode` in 5 — CP0 ExcCode.
- `MEM_Valid`, `MEM_PC`, `MEM_ALUOut`, `MEM_OutB`, `MEM_Dst`, `MEM_RegsWrType`, `MEM_LoadType`, `MEM_StoreType`, `MEM_IsInDelaySlot`, `MEM_HasExc`, `MEM_ExcCode` out — registered copies, same widths.
- `MEM_IsLoad` out 1 — registered, equals (`MEM_LoadType` != 0); consumed by the load-use hazard check.

## Operation
- Update priority per edge: `rst` > `MEM_Flush` > `!MEM_Wr` (hold) > capture.
- Reset and flush produce an identical bubble:
  - `MEM_PC` = `PC_RESET`.
  - All other outputs = 0.
- Hold: every output keeps its value exactly, including `MEM_IsLoad`.
- Capture: every `MEM_*` takes its `EXE_*` value, with these sanitisation rules applied at capture time.
- Write suppression: if `!EXE_Valid` or `EXE_HasExc`:
  - `MEM_RegsWrType` = 0, `MEM_Dst` = 0.
  - `MEM_LoadType` = 0, `MEM_StoreType` = 0, `MEM_IsLoad` = 0.
- A faulting instruction still carries `PC`, `HasExc`, `ExcCode` and `IsInDelaySlot` to MEM for CP0 commit.
- Invalid-slot rule: if `!EXE_Valid`, `MEM_HasExc` = 0 and `MEM_ExcCode` = 0.
- Dst normalisation: if the captured RFWr bit is 0, `MEM_Dst` = 0. Guaranteed invariant: `MEM_Dst` != 0 implies `MEM_RegsWrType[3]` = 1 and `MEM_Valid` = 1.
- Load/store exclusivity: if both `EXE_LoadType` and `EXE_StoreType` are nonzero (illegal decode), the load is kept and `MEM_StoreType` = 0.
- `MEM_IsLoad` is computed from the sanitised load type, never from raw `EXE_LoadType`.
- No combinational path from any input to any output.

## Timing
- Latency 1 cycle: EXE bundle at edge N appears on MEM outputs after edge N.
- Single-cycle flush: `MEM_Flush` high at edge N → bubble after N, regardless of `MEM_Wr`.
- Flush and stall together: flush wins; the hold resumes on the bubble.
- Stall of k cycles: outputs constant for k cycles. The capture on the first edge with `MEM_Wr` = 1 takes the EXE bundle present at that edge.
- Reset mid-stall or mid-flush: reset wins; the bubble is visible the cycle after the `rst` edge.
- `rst` held for multiple cycles: outputs stay at the bubble values.

## Test plan
- Reset: `rst` = 1 for 2 cycles with arbitrary EXE inputs → `MEM_PC` = 32'hBFC0_0000; `MEM_Valid`, `MEM_RegsWrType`, `MEM_Dst`, `MEM_IsLoad` all 0.
- Capture: EXE_Valid = 1, PC = 32'hBFC0_0010, ALUOut = 32'h1234_5678, Dst = 5'd8, RegsWrType = 4'b1000, LoadType = 5 (LW), `MEM_Wr` = 1 → next cycle `MEM_Dst` = 8, `MEM_IsLoad` = 1, `MEM_ALUOut` = 32'h1234_5678.
- Stall: after the capture above, `MEM_Wr` = 0 for 3 cycles while EXE inputs change to Dst = 5'd9 → outputs stay Dst = 8 for all 3 cycles; Dst = 9 appears the cycle after `MEM_Wr` returns to 1.
- Flush vs stall: `MEM_Flush` = 1 and `MEM_Wr` = 0 on the same edge while MEM holds a valid LW → bubble: `MEM_Valid` = 0, `MEM_IsLoad` = 0, `MEM_PC` = `PC_RESET`.
- Exception suppression: EXE_HasExc = 1, ExcCode = 5'h04, RegsWrType = 4'b1000, Dst = 5'd3, StoreType = 3 → `MEM_HasExc` = 1, `MEM_ExcCode` = 5'h04, `MEM_RegsWrType` = 0, `MEM_Dst` = 0, `MEM_StoreType` = 0.
- Dst normalisation and illegal decode: RegsWrType = 4'b0100, Dst = 5'd12, LoadType = 1, StoreType = 2 → `MEM_Dst` = 0, `MEM_LoadType` = 1, `MEM_StoreType` = 0, `MEM_IsLoad` = 1.

Source files
------------

// File: rtl/exe_mem_reg.sv
//=============================================================================
// Module   : exe_mem_reg
// Purpose  : EXE->MEM pipeline register of the five-stage core. Captures the
//            EXE-stage result bundle on every enabled cycle and presents it
//            as the MEM-stage bundle. This bundle feeds:
//              - the EXE-stage forward unit (MEM_Dst, MEM_RegsWrType,
//                MEM_ALUOut)
//              - the data-memory request logic
//              - the hazard unit
//            It owns the stall/flush bubble behaviour at this boundary and
//            strips architectural side effects from invalid or faulting
//            instructions.
//
// Ports    : clk, rst              - core clock, synchronous active-high reset
//            MEM_Flush             - replace contents with a bubble
//            MEM_Wr                - capture enable (0 = hold / stall)
//            EXE_*                 - incoming EXE-stage bundle
//            MEM_*                 - registered, sanitised MEM-stage bundle
//            MEM_IsLoad            - registered (MEM_LoadType != 0)
//
// Revision : 1.0 - initial release
//=============================================================================
`default_nettype none

module exe_mem_reg #(
    parameter logic [31:0] PC_RESET = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_Flush,
    input  logic        MEM_Wr,

    input  logic        EXE_Valid,
    input  logic [31:0] EXE_PC,
    input  logic [31:0] EXE_ALUOut,
    input  logic [31:0] EXE_OutB,
    input  logic [4:0]  EXE_Dst,
    input  logic [3:0]  EXE_RegsWrType,
    input  logic [2:0]  EXE_LoadType,
    input  logic [1:0]  EXE_StoreType,
    input  logic        EXE_IsInDelaySlot,
    input  logic        EXE_HasExc,
    input  logic [4:0]  EXE_ExcCode,

    output logic        MEM_Valid,
    output logic [31:0] MEM_PC,
    output logic [31:0] MEM_ALUOut,
    output logic [31:0] MEM_OutB,
    output logic [4:0]  MEM_Dst,
    output logic [3:0]  MEM_RegsWrType,
    output logic [2:0]  MEM_LoadType,
    output logic [1:0]  MEM_StoreType,
    output logic        MEM_IsInDelaySlot,
    output logic        MEM_HasExc,
    output logic [4:0]  MEM_ExcCode,
    output logic        MEM_IsLoad
);

    //-------------------------------------------------------------------------
    // Capture-time sanitisation of the EXE bundle
    //-------------------------------------------------------------------------
    // An invalid slot or a faulting instruction must not write GPR/CP0/HI/LO
    // and must not touch data memory. A faulting instruction still travels on
    // with its PC, exception info and delay-slot flag so CP0 can commit it.
    logic        w_kill;
    logic [3:0]  w_regs_wr_type;
    logic [4:0]  w_dst;
    logic [2:0]  w_load_type;
    logic [1:0]  w_store_type;
    logic        w_has_exc;
    logic [4:0]  w_exc_code;
    logic        w_is_load;

    always_comb begin
        w_kill         = (~EXE_Valid) | EXE_HasExc;

        w_regs_wr_type = w_kill ? 4'd0 : EXE_RegsWrType;

        // Only an actual RF write keeps a destination; this keeps the
        // forward unit from matching on stale Dst fields.
        w_dst          = (w_kill | ~EXE_RegsWrType[3]) ? 5'd0 : EXE_Dst;

        w_load_type    = w_kill ? 3'd0 : EXE_LoadType;

        // Illegal decode with both load and store set: keep the load.
        w_store_type   = (w_kill || (EXE_LoadType != 3'd0)) ? 2'd0 : EXE_StoreType;

        // An empty slot cannot raise an exception.
        w_has_exc      = EXE_Valid ? EXE_HasExc  : 1'b0;
        w_exc_code     = EXE_Valid ? EXE_ExcCode : 5'd0;

        // Derived from the sanitised load type, not the raw decode.
        w_is_load      = (w_load_type != 3'd0);
    end

    //-------------------------------------------------------------------------
    // Pipeline register: rst > flush > hold > capture
    //-------------------------------------------------------------------------
    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_alu_out;
    logic [31:0] r_out_b;
    logic [4:0]  r_dst;
    logic [3:0]  r_regs_wr_type;
    logic [2:0]  r_load_type;
    logic [1:0]  r_store_type;
    logic        r_is_in_delay_slot;
    logic        r_has_exc;
    logic [4:0]  r_exc_code;
    logic        r_is_load;

    always_ff @(posedge clk) begin
        if (rst || MEM_Flush) begin
            // Reset and flush produce the same bubble.
            r_valid            <= 1'b0;
            r_pc               <= PC_RESET;
            r_alu_out          <= 32'd0;
            r_out_b            <= 32'd0;
            r_dst              <= 5'd0;
            r_regs_wr_type     <= 4'd0;
            r_load_type        <= 3'd0;
            r_store_type       <= 2'd0;
            r_is_in_delay_slot <= 1'b0;
            r_has_exc          <= 1'b0;
            r_exc_code         <= 5'd0;
            r_is_load          <= 1'b0;
        end else if (MEM_Wr) begin
            r_valid            <= EXE_Valid;
            r_pc               <= EXE_PC;
            r_alu_out          <= EXE_ALUOut;
            r_out_b            <= EXE_OutB;
            r_dst              <= w_dst;
            r_regs_wr_type     <= w_regs_wr_type;
            r_load_type        <= w_load_type;
            r_store_type       <= w_store_type;
            r_is_in_delay_slot <= EXE_IsInDelaySlot;
            r_has_exc          <= w_has_exc;
            r_exc_code         <= w_exc_code;
            r_is_load          <= w_is_load;
        end
        // MEM_Wr == 0: every field holds its value.
    end

    //-------------------------------------------------------------------------
    // Outputs come straight from flops: no input-to-output comb path.
    //-------------------------------------------------------------------------
    assign MEM_Valid         = r_valid;
    assign MEM_PC            = r_pc;
    assign MEM_ALUOut        = r_alu_out;
    assign MEM_OutB          = r_out_b;
    assign MEM_Dst           = r_dst;
    assign MEM_RegsWrType    = r_regs_wr_type;
    assign MEM_LoadType      = r_load_type;
    assign MEM_StoreType     = r_store_type;
    assign MEM_IsInDelaySlot = r_is_in_delay_slot;
    assign MEM_HasExc        = r_has_exc;
    assign MEM_ExcCode       = r_exc_code;
    assign MEM_IsLoad        = r_is_load;

endmodule

`default_nettype wire
